// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing with an internal
// register file and ALU, external instruction/data memories behind req/ack handshakes.
module mips_mc_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int NREG   = 32,
  parameter int LED_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [LED_W-1:0]  led_output,
  output logic [2:0]        state,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3E;
  localparam logic [5:0] OP_OUT   = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam int RI_W = $clog2(NREG);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd, wb_idx;
  logic [DATA_W-1:0] imm_x, rs_val, rt_val;
  logic [PC_W-1:0]   pc_off;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign wb_idx = (op == OP_RTYPE) ? rd : rt;

  // Sign-extend imm to the datapath and PC widths; narrow widths keep only the low bits.
  always_comb begin
    imm_x  = '0;
    pc_off = '0;
    for (int i = 0; i < DATA_W; i++) imm_x[i] = ir_q[(i < 16) ? i : 15];
    for (int i = 0; i < PC_W; i++) pc_off[i] = ir_q[(i < 16) ? i : 15];
  end

  // Register 0 and unimplemented indices read as zero.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && int'(rs) < NREG) rs_val = rf_q[rs[RI_W-1:0]];
    if (rt != 5'd0 && int'(rt) < NREG) rt_val = rf_q[rt[RI_W-1:0]];
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    led_d   = led_q;
    rf_d    = rf_q;

    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          OP_RTYPE: begin
            state_d = WB;
            case (funct)
              FN_ADD:  alu_d = a_q + b_q;
              FN_SUB:  alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              FN_SLT:  alu_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
              default: state_d = FETCH;
            endcase
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_x;
            state_d = WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_x;
            state_d = MEM;
          end
          OP_BEQ:  if (a_q == b_q) pc_d = pc_q + pc_off;
          OP_J:    pc_d = ir_q[PC_W-1:0];
          OP_OUT:  led_d = a_q[LED_W-1:0];
          OP_HALT: state_d = HALT;
          default: ;
        endcase
      end
      MEM: begin
        if (dmem_ack) begin
          if (op == OP_LW) begin
            mdr_d   = dmem_rdata;
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WB: begin
        if (wb_idx != 5'd0 && int'(wb_idx) < NREG)
          rf_d[wb_idx[RI_W-1:0]] = (op == OP_LW) ? mdr_q : alu_q;
        state_d = FETCH;
      end
      HALT:    ;
      default: state_d = FETCH;
    endcase
  end

  // NOTE: the register file is reset like any other state because software may rely on zeroed registers after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      led_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      led_q   <= led_d;
      rf_q    <= rf_d;
    end
  end

  // Requests depend on state only; rst gates them so they drop while reset is held.
  assign imem_req   = (state_q == FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == MEM) && !rst;
  assign dmem_we    = (state_q == MEM) && (op == OP_SW);
  assign dmem_addr  = alu_q;
  assign dmem_wdata = b_q;
  assign led_output = led_q;
  assign state      = state_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: behavioural memories with programmable wait states, an LED
// scoreboard, and monitors for fetch order/timing and data-access stability.
`timescale 1ns/1ps
module tb_mips_mc_core;
  localparam int DATA_W = 8;
  localparam int PC_W   = 8;
  localparam int NREG   = 32;
  localparam int LED_W  = 8;

  localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B, OP_HALT = 6'h3E, OP_OUT = 6'h3F;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [LED_W-1:0]  led_output;
  logic [2:0]        state;

  mips_mc_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREG(NREG), .LED_W(LED_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .led_output(led_output), .state(state), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: ack arrives once the request has been up for more than iwait/dwait cycles.
  logic [31:0]       imem [256];
  logic [DATA_W-1:0] dmem [256] = '{default: '0};
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  bit i_hold = 1'b0, stray = 1'b0;

  assign imem_ack   = (imem_req && !i_hold && icnt >= iwait) || (stray && !imem_req);
  assign dmem_ack   = (dmem_req && dcnt >= dwait) || (stray && !dmem_req);
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end
  end

  always @(posedge clk) if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;

  // Scoreboard and trace queues.
  logic [LED_W-1:0]  exp_led [$];
  logic [PC_W-1:0]   fa_addr [$];
  int                fa_cyc  [$];
  logic [DATA_W-1:0] da_addr [$];
  logic              da_we   [$];
  logic [DATA_W-1:0] da_wdata[$];
  int                da_len  [$];
  int                halt_cyc = -1;

  logic [LED_W-1:0]  led_prev = '0;
  logic [LED_W-1:0]  exp_v;
  bit                d_active = 1'b0;
  logic [DATA_W-1:0] d_addr, d_wdata;
  logic              d_we;
  int                d_len = 0;

  always @(negedge clk) begin
    if (rst) begin
      led_prev = led_output;
      d_active = 1'b0;
    end else begin
      if (led_output !== led_prev) begin
        tests_run++;
        if (exp_led.size() == 0) begin
          tests_failed++;
          $display("FAIL led_unexpected: led_output=%h with no value pending", led_output);
        end else begin
          exp_v = exp_led.pop_front();
          if (led_output !== exp_v) begin
            tests_failed++;
            $display("FAIL led_value: got %h, expected %h", led_output, exp_v);
          end
        end
        led_prev = led_output;
      end
      tests_run++;
      if (imem_req && dmem_req) begin
        tests_failed++;
        $display("FAIL req_exclusive: imem_req=%b dmem_req=%b, expected not both", imem_req, dmem_req);
      end
      if (imem_req && imem_ack) begin
        fa_addr.push_back(imem_addr);
        fa_cyc.push_back(cyc);
      end
      if (dmem_req) begin
        if (!d_active) begin
          d_active = 1'b1;
          d_addr   = dmem_addr;
          d_we     = dmem_we;
          d_wdata  = dmem_wdata;
          d_len    = 0;
        end else begin
          tests_run++;
          if ({dmem_addr, dmem_we, dmem_wdata} !== {d_addr, d_we, d_wdata}) begin
            tests_failed++;
            $display("FAIL dmem_hold: addr/we/wdata=%h/%b/%h, held %h/%b/%h",
                     dmem_addr, dmem_we, dmem_wdata, d_addr, d_we, d_wdata);
          end
        end
        d_len++;
        if (dmem_ack) begin
          da_addr.push_back(d_addr);
          da_we.push_back(d_we);
          da_wdata.push_back(d_wdata);
          da_len.push_back(d_len);
          d_active = 1'b0;
        end
      end
      if (halted && halt_cyc < 0) halt_cyc = cyc;
    end
  end

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] r_type(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 26'd0};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_led.delete();
    fa_addr.delete();
    fa_cyc.delete();
    da_addr.delete();
    da_we.delete();
    da_wdata.delete();
    da_len.delete();
    halt_cyc = -1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    ok = halted;
  endtask

  task automatic test_reset();
    int n;
    clear_imem();
    imem[0] = i_type(OP_ADDI, 0, 1, 8'h2C);
    imem[1] = i_type(OP_OUT, 1, 0, 0);
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0 || state !== 3'd0 || halted !== 1'b0 || led_output !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: req=%b/%b state=%0d halted=%b led=%h, expected 0/0/0/0/00",
               imem_req, dmem_req, state, halted, led_output);
    end
    do_reset();
    exp_led.push_back(8'h2C);
    n = 0;
    while (led_output !== 8'h2C && n < 50) begin
      @(negedge clk);
      n++;
    end
    i_hold = 1'b1;
    tests_run++;
    if (led_output !== 8'h2C) begin
      tests_failed++;
      $display("FAIL reset_prerun: led=%h, expected 2c", led_output);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd2) begin
      tests_failed++;
      $display("FAIL reset_stall: imem_req=%b addr=%h, expected 1/02", imem_req, imem_addr);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b0 || led_output !== '0 || imem_addr !== '0 || state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_midfetch: req=%b led=%h addr=%h state=%0d, expected 0/00/00/0",
               imem_req, led_output, imem_addr, state);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== '0 || led_output !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: req=%b addr=%h led=%h, expected 1/00/00", imem_req, imem_addr, led_output);
    end
    i_hold = 1'b0;
    tests_run++;
    if (exp_led.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_sb: %0d led values pending, expected 0", exp_led.size());
    end
  endtask

  task automatic test_arith();
    bit ok;
    logic [LED_W-1:0] exp_seq [6] = '{8'h81, 8'h01, 8'h83, 8'h7F, 8'h01, 8'h00};
    clear_imem();
    imem[0]  = i_type(OP_ADDI, 0, 1, 8'h7F);
    imem[1]  = i_type(OP_ADDI, 0, 2, 8'h02);
    imem[2]  = r_type(FN_ADD, 3, 1, 2);
    imem[3]  = r_type(FN_SLT, 4, 3, 1);
    imem[4]  = i_type(OP_OUT, 3, 0, 0);
    imem[5]  = i_type(OP_OUT, 4, 0, 0);
    imem[6]  = r_type(FN_SUB, 5, 2, 1);
    imem[7]  = i_type(OP_OUT, 5, 0, 0);
    imem[8]  = r_type(FN_OR, 6, 1, 2);
    imem[9]  = i_type(OP_OUT, 6, 0, 0);
    imem[10] = r_type(FN_AND, 7, 3, 1);
    imem[11] = i_type(OP_OUT, 7, 0, 0);
    imem[12] = r_type(FN_SLT, 8, 1, 3);
    imem[13] = i_type(OP_OUT, 8, 0, 0);
    do_reset();
    foreach (exp_seq[i]) exp_led.push_back(exp_seq[i]);
    wait_halt(300, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL arith_timeout: halted=%b, expected 1", halted);
    end
    tests_run++;
    if (exp_led.size() != 0) begin
      tests_failed++;
      $display("FAIL arith_sb: %0d led values pending, expected 0", exp_led.size());
    end
    tests_run++;
    if (fa_addr.size() != 15) begin
      tests_failed++;
      $display("FAIL arith_fetch_count: %0d fetches, expected 15", fa_addr.size());
    end else begin
      for (int i = 0; i < 15; i++) begin
        tests_run++;
        if (fa_addr[i] !== 8'(i)) begin
          tests_failed++;
          $display("FAIL arith_fetch_order: fetch %0d addr=%h, expected %h", i, fa_addr[i], 8'(i));
        end
      end
      tests_run++;
      if (fa_cyc[3] - fa_cyc[2] != 4 || fa_cyc[1] - fa_cyc[0] != 4) begin
        tests_failed++;
        $display("FAIL arith_rtype_latency: ADD %0d ADDI %0d cycles, expected 4/4",
                 fa_cyc[3] - fa_cyc[2], fa_cyc[1] - fa_cyc[0]);
      end
      tests_run++;
      if (fa_cyc[5] - fa_cyc[4] != 3) begin
        tests_failed++;
        $display("FAIL arith_out_latency: %0d cycles, expected 3", fa_cyc[5] - fa_cyc[4]);
      end
      tests_run++;
      if (halt_cyc - fa_cyc[14] != 3) begin
        tests_failed++;
        $display("FAIL halt_latency: %0d cycles, expected 3", halt_cyc - fa_cyc[14]);
      end
    end
  endtask

  task automatic test_ldst();
    bit ok;
    iwait = 2;
    dwait = 3;
    clear_imem();
    imem[0] = i_type(OP_ADDI, 0, 1, 8'h5A);
    imem[1] = i_type(OP_ADDI, 0, 2, 7);
    imem[2] = i_type(OP_SW, 2, 1, -2);
    imem[3] = i_type(OP_LW, 2, 6, -2);
    imem[4] = i_type(OP_OUT, 6, 0, 0);
    do_reset();
    exp_led.push_back(8'h5A);
    wait_halt(300, ok);
    tests_run++;
    if (!ok || exp_led.size() != 0) begin
      tests_failed++;
      $display("FAIL ldst_done: halted=%b pending=%0d, expected 1/0", halted, exp_led.size());
    end
    tests_run++;
    if (da_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL ldst_count: %0d data accesses, expected 2", da_addr.size());
    end else begin
      tests_run++;
      if (da_addr[0] !== 8'd5 || da_we[0] !== 1'b1 || da_wdata[0] !== 8'h5A || da_len[0] != 4) begin
        tests_failed++;
        $display("FAIL ldst_store: addr=%h we=%b wdata=%h len=%0d, expected 05/1/5a/4",
                 da_addr[0], da_we[0], da_wdata[0], da_len[0]);
      end
      tests_run++;
      if (da_addr[1] !== 8'd5 || da_we[1] !== 1'b0 || da_len[1] != 4) begin
        tests_failed++;
        $display("FAIL ldst_load: addr=%h we=%b len=%0d, expected 05/0/4", da_addr[1], da_we[1], da_len[1]);
      end
    end
    tests_run++;
    if (fa_cyc.size() < 5) begin
      tests_failed++;
      $display("FAIL ldst_fetch_count: %0d fetches, expected 6", fa_cyc.size());
    end else if (fa_cyc[3] - fa_cyc[2] != 9 || fa_cyc[4] - fa_cyc[3] != 10) begin
      tests_failed++;
      $display("FAIL ldst_latency: SW %0d LW %0d cycles, expected 9/10",
               fa_cyc[3] - fa_cyc[2], fa_cyc[4] - fa_cyc[3]);
    end
    iwait = 0;
    dwait = 0;
  endtask

  task automatic test_branch();
    bit ok;
    int n;
    logic [PC_W-1:0] exp_a [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    logic [PC_W-1:0] exp_b [6] = '{8'd0, 8'd6, 8'd7, 8'hFF, 8'd0, 8'd1};
    clear_imem();
    imem[0] = i_type(OP_ADDI, 0, 1, 1);
    imem[1] = i_type(OP_ADDI, 0, 2, 2);
    imem[2] = i_type(OP_BEQ, 1, 2, 10);
    imem[3] = i_type(OP_BEQ, 0, 0, -1);
    do_reset();
    n = 0;
    while (fa_addr.size() < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (fa_addr.size() < 6) begin
      tests_failed++;
      $display("FAIL beq_timeout: %0d fetches, expected 6", fa_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (fa_addr[i] !== exp_a[i]) begin
          tests_failed++;
          $display("FAIL beq_order: fetch %0d addr=%h, expected %h", i, fa_addr[i], exp_a[i]);
        end
      end
      tests_run++;
      if (fa_cyc[3] - fa_cyc[2] != 3 || fa_cyc[4] - fa_cyc[3] != 3) begin
        tests_failed++;
        $display("FAIL beq_latency: %0d/%0d cycles, expected 3/3", fa_cyc[3] - fa_cyc[2], fa_cyc[4] - fa_cyc[3]);
      end
    end

    clear_imem();
    imem[0]     = i_type(OP_BEQ, 1, 0, 5);
    imem[6]     = i_type(OP_ADDI, 0, 1, 1);
    imem[7]     = {OP_J, 26'h00000FF};
    imem[8'hFF] = i_type(OP_OUT, 1, 0, 0);
    do_reset();
    exp_led.push_back(8'h01);
    wait_halt(100, ok);
    tests_run++;
    if (!ok || exp_led.size() != 0 || fa_addr.size() != 6) begin
      tests_failed++;
      $display("FAIL jump_done: halted=%b pending=%0d fetches=%0d, expected 1/0/6", halted, exp_led.size(), fa_addr.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (fa_addr[i] !== exp_b[i]) begin
          tests_failed++;
          $display("FAIL jump_order: fetch %0d addr=%h, expected %h", i, fa_addr[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_r0_undef();
    bit ok;
    clear_imem();
    imem[0] = i_type(OP_ADDI, 0, 0, 5);
    imem[1] = i_type(OP_ADDI, 0, 1, 8'h33);
    imem[2] = i_type(OP_OUT, 1, 0, 0);
    imem[3] = i_type(OP_OUT, 0, 0, 0);
    imem[4] = i_type(OP_ADDI, 0, 2, 8'h44);
    imem[5] = {6'h11, 5'd2, 5'd3, 16'h1234};
    imem[6] = r_type(6'h03, 2, 1, 1);
    imem[7] = i_type(OP_OUT, 2, 0, 0);
    imem[8] = i_type(OP_OUT, 3, 0, 0);
    do_reset();
    stray = 1'b1;
    exp_led.push_back(8'h33);
    exp_led.push_back(8'h00);
    exp_led.push_back(8'h44);
    exp_led.push_back(8'h00);
    wait_halt(200, ok);
    stray = 1'b0;
    tests_run++;
    if (!ok || exp_led.size() != 0) begin
      tests_failed++;
      $display("FAIL undef_done: halted=%b pending=%0d, expected 1/0", halted, exp_led.size());
    end
    tests_run++;
    if (fa_addr.size() != 10) begin
      tests_failed++;
      $display("FAIL undef_fetch_count: %0d fetches, expected 10", fa_addr.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (fa_addr[i] !== 8'(i)) begin
          tests_failed++;
          $display("FAIL undef_order: fetch %0d addr=%h, expected %h", i, fa_addr[i], 8'(i));
        end
      end
      tests_run++;
      if (fa_cyc[6] - fa_cyc[5] != 3 || fa_cyc[7] - fa_cyc[6] != 3) begin
        tests_failed++;
        $display("FAIL undef_latency: %0d/%0d cycles, expected 3/3", fa_cyc[6] - fa_cyc[5], fa_cyc[7] - fa_cyc[6]);
      end
    end
  endtask

  task automatic test_halt();
    bit ok;
    clear_imem();
    do_reset();
    wait_halt(50, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL halt_reach: halted=%b, expected 1", halted);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests_run++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || dmem_req !== 1'b0 || state !== 3'd7) begin
        tests_failed++;
        $display("FAIL halt_hold: cycle %0d halted=%b req=%b/%b state=%0d, expected 1/0/0/7",
                 i, halted, imem_req, dmem_req, state);
      end
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (halted !== 1'b0 || state !== 3'd0) begin
      tests_failed++;
      $display("FAIL halt_reset: halted=%b state=%0d, expected 0/0", halted, state);
    end
    fa_addr.delete();
    fa_cyc.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (fa_addr.size() < 1 || fa_addr[0] !== '0) begin
      tests_failed++;
      $display("FAIL halt_restart: %0d fetches, first addr %h, expected >=1 at 00",
               fa_addr.size(), (fa_addr.size() > 0) ? fa_addr[0] : 8'hXX);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ldst();
    test_branch();
    test_r0_undef();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_mc_core.md
Name: mips_mc_core

Overview:
- Parametrised multi-cycle MIPS-subset core; successor to the fixed 8-bit, memory-less top-level.
- Sequences FETCH/DECODE/EXEC/MEM/WB with an internal register file and ALU.
- Instruction and data memory are external, behind req/ack handshakes that allow arbitrary wait states.
- Adds reset, branches, jumps, stores, halt, and a parametrised LED output register.

Parameters:
- DATA_W, 8: datapath and register width (8..32).
- PC_W, 8: program-counter width; PC is a word index.
- NREG, 32: implemented registers (2..32); reads of registers at index ≥NREG return 0, writes to them are ignored.
- LED_W, 8: led_output width (≤DATA_W).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch word address (= PC).
- imem_rdata  in  32  instruction word; valid when imem_ack.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DATA_W  data address (rs + sign-extended imm).
- dmem_wdata  out  DATA_W  store data (R[rt]).
- dmem_rdata  in  DATA_W  load data; valid when dmem_ack.
- dmem_ack  in  1  data access complete.
- led_output  out  LED_W  display register.
- state  out  3  current FSM state (debug).
- halted  out  1  core is in HALT.

Behaviour:
- Reset (asynchronous, active-high):
  - PC=0, all registers 0, led_output=0, IR=0, state=FETCH.
  - imem_req/dmem_req drop immediately; any outstanding transfer is abandoned.
  - halted=0.
- FSM encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On the edge where imem_ack=1: IR<=imem_rdata, PC<=PC+1 (wraps mod 2^PC_W), go to DECODE.
  - Without ack, stay in FETCH.
- DECODE: latch A=R[rs], B=R[rt]; register 0 always reads 0. Go to EXEC.
- Instruction fields:
  - op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
  - imm is sign-extended to DATA_W; if DATA_W<16, the low DATA_W bits are used.
- EXEC, by opcode:
  - 0x00 R-type, funct 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed):
    - ALUOut <= result, go to WB.
    - Arithmetic wraps mod 2^DATA_W; no overflow trap.
  - 0x08 ADDI: ALUOut=A+imm, go to WB.
  - 0x23 LW and 0x2B SW: ALUOut=A+imm, go to MEM.
  - 0x04 BEQ: if A==B, PC<=PC+imm[PC_W-1:0] (PC already incremented), wrapping. Go to FETCH.
  - 0x02 J: PC<=IR[PC_W-1:0], go to FETCH.
  - 0x3F OUT: led_output<=A[LED_W-1:0], go to FETCH.
  - 0x3E HALT: go to HALT.
  - Undefined opcode or funct: no architectural effect, go to FETCH.
- MEM:
  - dmem_req=1, dmem_addr=ALUOut, dmem_we=(op==SW), dmem_wdata=B.
  - All four outputs are held stable until ack.
  - On the ack edge: SW goes to FETCH; LW captures MDR<=dmem_rdata and goes to WB.
- WB:
  - Destination: R-type writes rd; ADDI/LW write rt.
  - Value: MDR for LW, ALUOut otherwise.
  - Writes to register 0 are discarded. Go to FETCH.
- HALT: halted=1; no requests; remains there until rst.
- Handshake rules:
  - req is asserted combinationally from state only.
  - ack while the matching req is low is ignored.
  - Single-cycle-ack latency (ack in the first req cycle):
    - R-type/ADDI: 4 cycles.
    - LW: 5 cycles.
    - SW: 4 cycles.
    - BEQ/J/OUT: 3 cycles.
    - HALT: 3 cycles to reach HALT.
  - Each wait cycle adds exactly one cycle.
- Only one memory request is outstanding at any time; imem_req and dmem_req are never both high.

Test Plan:
- Reset mid-fetch: assert rst while imem_req=1 and ack is withheld -> imem_req=0 the same cycle; after release, imem_addr=0 and led_output=0.
- Arithmetic, DATA_W=8, zero-wait memory:
  - Program: ADDI r1,r0,0x7F; ADDI r2,r0,0x02; ADD r3,r1,r2; SLT r4,r3,r1; OUT r3; OUT r4.
  - Required: led_output=0x81, then 0x01.
  - ADD completes 4 cycles after its fetch begins.
- Load/store with 3 wait states: SW r1 to address 5, then LW r6 from address 5, then OUT r6.
  - dmem_addr=5 with dmem_we=1, then dmem_we=0.
  - Signals are held stable through the waits.
  - led_output equals the stored value.
- Branch/jump:
  - BEQ r0,r0,-1 at PC=3 -> PC refetches 3.
  - J 0xFF with PC_W=8 -> next imem_addr=0xFF; PC then wraps to 0x00.
- Register 0 and undefined encodings: ADDI r0,r0,5 then OUT r0 -> led_output=0; undefined opcode 0x11 -> no register, PC or LED change beyond PC+1.
- HALT: after HALT, halted=1 and no req for 20 cycles; rst clears halted and fetching restarts at 0.
